// File: rtl/mvm_result_drain_if.sv
// MVM drain port bundle: pass control, MVM link
// and the result stream with its handshake.
interface mvm_result_drain_if #(
  parameter int NUM_BIT = 16,
  parameter int DIM     = 8,
  parameter int CNT_W   = 24
);
  localparam int IW = $clog2(DIM);

  logic                        i_go;
  logic                        i_relu_en;
  logic                        o_busy;
  logic                        o_start_mvm;
  logic                        i_ismvm;
  logic [DIM-1:0][NUM_BIT-1:0] i_wx_result;
  logic [NUM_BIT-1:0]          o_data;
  logic [IW-1:0]               o_idx;
  logic                        o_valid;
  logic                        i_ready;
  logic                        o_last;
  logic [CNT_W-1:0]            o_cycles;
  logic                        o_err;

  modport master (
    input  i_go, i_relu_en, i_ismvm,
    input  i_wx_result, i_ready,
    output o_busy, o_start_mvm,
    output o_data, o_idx, o_valid,
    output o_last, o_cycles, o_err
  );

  modport slave (
    output i_go, i_relu_en, i_ismvm,
    output i_wx_result, i_ready,
    input  o_busy, o_start_mvm,
    input  o_data, o_idx, o_valid,
    input  o_last, o_cycles, o_err
  );
endinterface

// File: rtl/mvm_result_drain.sv
// MVM pass controller: start pulse, busy tracking,
// result capture and element-wise drain with ReLU.
module mvm_result_drain #(
  parameter int NUM_BIT   = 16,
  parameter int DIM       = 8,
  parameter int FRAC      = 8,
  parameter int CNT_W     = 24,
  parameter int RISE_WAIT = 8
) (
  input  logic               i_clk_drn,
  input  logic               i_rst_n_drn,
  mvm_result_drain_if.master bus
);
  localparam int IW = $clog2(DIM);
  localparam int WW =
    (RISE_WAIT > 1) ? $clog2(RISE_WAIT) : 1;
  localparam logic [IW-1:0] ILAST =
    IW'(DIM - 1);
  localparam logic [WW-1:0] WLIM =
    WW'(RISE_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_RISE,
    RUN,
    DRAIN
  } state_t;

  state_t                      state;
  logic                        relu;
  logic                        err;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_nx;
  logic [CNT_W-1:0]            cycles;
  logic [WW-1:0]               wcnt;
  logic [IW-1:0]               idx;
  logic [DIM-1:0][NUM_BIT-1:0] rbuf;
  logic [NUM_BIT-1:0]          cur;

  assign cnt_nx = (&cnt) ? cnt : cnt + 1'b1;

  // Pass sequencing, capture, latency and drain index
  always_ff @(posedge i_clk_drn) begin
    if (!i_rst_n_drn) begin
      state  <= IDLE;
      relu   <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      cycles <= '0;
      wcnt   <= '0;
      idx    <= '0;
      rbuf   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_go) begin
            relu  <= bus.i_relu_en;
            err   <= 1'b0;
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          cnt   <= cnt_nx;
          wcnt  <= '0;
          state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          cnt <= cnt_nx;
          if (bus.i_ismvm) begin
            rbuf  <= bus.i_wx_result;
            state <= RUN;
          end else if (wcnt == WLIM) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt_nx;
          if (bus.i_ismvm) begin
            rbuf <= bus.i_wx_result;
          end else begin
            cycles <= cnt_nx;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.i_ready) begin
            if (idx == ILAST) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur = rbuf[idx];

  assign bus.o_busy      = (state != IDLE);
  assign bus.o_start_mvm = (state == START);
  assign bus.o_valid     = (state == DRAIN);
  assign bus.o_last      =
    (state == DRAIN) && (idx == ILAST);
  assign bus.o_idx       = idx;
  assign bus.o_cycles    = cycles;
  assign bus.o_err       = err;
  assign bus.o_data      =
    (relu && cur[NUM_BIT-1]) ? '0 : cur;
endmodule

// File: tb/tb_mvm_result_drain.sv
// Bench for mvm_result_drain: randomized passes
// against a transaction-level model of the stream.
module tb_mvm_result_drain;
  localparam int NB = 16;
  localparam int D  = 8;
  localparam int CW = 24;
  localparam int RW = 8;

  typedef logic [D-1:0][NB-1:0] vec_t;
  typedef struct packed {
    logic [NB-1:0] data;
    logic [2:0]    idx;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mvm_result_drain_if #(
    .NUM_BIT(NB), .DIM(D), .CNT_W(CW)
  ) bus ();

  mvm_result_drain #(
    .NUM_BIT(NB), .DIM(D), .FRAC(8),
    .CNT_W(CW), .RISE_WAIT(RW)
  ) dut (
    .i_clk_drn  (clk),
    .i_rst_n_drn(rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int ready_mode = 0;
  beat_t exp_q[$];
  logic [NB-1:0] obs [D];

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               n, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] relu_f(
      input logic [NB-1:0] v, input bit en);
    if (en && $signed(v) < 0) return '0;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < D; i++)
      v[i] = NB'($urandom);
    return v;
  endfunction

  // ready driver: 0 always, 1 alternating, 2 random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.i_ready = 1'b1;
      1: bus.i_ready = ~bus.i_ready;
      default: bus.i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // stream compare against the expected beat queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_start_mvm) starts++;
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d data %0h expected none",
                   bus.o_idx, bus.o_data);
        end else begin
          chk("beat_data", bus.o_data, exp_q[0].data);
          chk("beat_idx", bus.o_idx, exp_q[0].idx);
          chk("beat_last", bus.o_last, exp_q[0].last);
          if (bus.i_ready) begin
            obs[bus.o_idx] = bus.o_data;
            exp_q.delete(0);
          end
        end
      end
    end
  end

  // one pass; d = edges after START edge before ismvm
  // is driven high, run_len = high samples
  task automatic run_pass(input bit relu,
                          input int d,
                          input int run_len,
                          input bit fixed,
                          input vec_t fv,
                          input bit go_busy,
                          input bit rst_mid,
                          output int exp_cyc);
    vec_t last_v;
    vec_t v;
    int e;
    int s0;
    bit hit;
    beat_t b;
    s0 = starts;
    @(posedge clk); #1;
    bus.i_go = 1'b1;
    bus.i_relu_en = relu;
    @(posedge clk); #1;
    bus.i_go = 1'b0;
    bus.i_relu_en = 1'($urandom);
    e = 0;
    chk("start_pulse", bus.o_start_mvm, 1);
    chk("busy_rise", bus.o_busy, 1);
    chk("err_clear", bus.o_err, 0);
    repeat (d) begin
      @(posedge clk); #1;
      e++;
    end
    last_v = '0;
    for (int j = 0; j < run_len; j++) begin
      v = fixed ? fv : rand_vec();
      bus.i_wx_result = v;
      bus.i_ismvm = 1'b1;
      last_v = v;
      bus.i_go = go_busy && (j == run_len / 2);
      @(posedge clk); #1;
      e++;
    end
    bus.i_go = 1'b0;
    bus.i_ismvm = 1'b0;
    bus.i_wx_result = rand_vec();
    @(posedge clk); #1;
    e++;
    exp_cyc = e;
    for (int i = 0; i < D; i++) begin
      b.data = relu_f(last_v[i], relu);
      b.idx = 3'(i);
      b.last = (i == D - 1);
      exp_q.push_back(b);
    end
    if (rst_mid) begin
      hit = 0;
      for (int n = 0; n < 200 && !hit; n++) begin
        @(negedge clk);
        hit = bus.o_valid && (bus.o_idx == 3);
      end
      chk("reach_idx3", hit, 1);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_cycles", bus.o_cycles, 0);
      chk("rst_idx", bus.o_idx, 0);
      exp_q.delete();
      rst_n = 1'b1;
      return;
    end
    for (int n = 0; n < 200 && bus.o_busy; n++) begin
      if (go_busy && n == 1) begin
        bus.i_go = 1'b1;
        bus.i_ismvm = 1'b1;
        bus.i_wx_result = rand_vec();
      end else begin
        bus.i_go = 1'b0;
        bus.i_ismvm = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.i_go = 1'b0;
    bus.i_ismvm = 1'b0;
    chk("drain_done", bus.o_busy, 0);
    chk("beats_left", exp_q.size(), 0);
    chk("cycles", bus.o_cycles, exp_cyc);
    chk("start_count", starts - s0, 1);
    chk("err_pass", bus.o_err, 0);
  endtask

  task automatic timeout_pass();
    @(posedge clk); #1;
    bus.i_go = 1'b1;
    bus.i_relu_en = 1'b0;
    bus.i_ismvm = 1'b0;
    @(posedge clk); #1;
    bus.i_go = 1'b0;
    for (int e = 1; e <= RW + 1; e++) begin
      @(posedge clk); #1;
      if (e == RW) begin
        chk("to_err_early", bus.o_err, 0);
        chk("to_busy_early", bus.o_busy, 1);
      end
    end
    chk("to_err", bus.o_err, 1);
    chk("to_busy", bus.o_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("to_err_sticky", bus.o_err, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vb;
    vec_t vr;
    int cyc;
    bus.i_go = 1'b0;
    bus.i_relu_en = 1'b0;
    bus.i_ismvm = 1'b0;
    bus.i_wx_result = '0;
    bus.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_busy", bus.o_busy, 0);
    chk("rst_o_start", bus.o_start_mvm, 0);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_last", bus.o_last, 0);
    chk("rst_o_err", bus.o_err, 0);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_o_idx", bus.o_idx, 0);
    chk("rst_o_cycles", bus.o_cycles, 0);
    rst_n = 1'b1;

    for (int i = 0; i < D; i++) vb[i] = NB'(i * 64);
    ready_mode = 0;
    run_pass(0, 1, 10, 1, vb, 0, 0, cyc);
    chk("basic_cycles_lit", bus.o_cycles, 12);
    chk("basic_b7_lit", obs[7], 448);
    chk("basic_b1_lit", obs[1], 64);

    ready_mode = 1;
    run_pass(0, 2, 5, 1, vb, 0, 0, cyc);

    vr = rand_vec();
    vr[0] = 16'hFF00;
    vr[1] = 16'h0180;
    ready_mode = 0;
    run_pass(1, 1, 3, 1, vr, 0, 0, cyc);
    chk("relu_b0_lit", obs[0], 16'h0000);
    chk("relu_b1_lit", obs[1], 16'h0180);
    run_pass(0, 1, 3, 1, vr, 0, 0, cyc);
    chk("norelu_b0_lit", obs[0], 16'hFF00);
    chk("norelu_b1_lit", obs[1], 16'h0180);

    timeout_pass();
    run_pass(0, 3, 4, 0, vb, 0, 0, cyc);

    run_pass(0, RW, 2, 0, vb, 0, 0, cyc);

    ready_mode = 0;
    run_pass(0, 1, 6, 0, vb, 0, 1, cyc);
    run_pass(1, 2, 4, 1, vb, 0, 0, cyc);
    chk("after_rst_b5_lit", obs[5], 320);

    ready_mode = 2;
    run_pass(0, 1, 8, 1, vb, 1, 0, cyc);

    for (int t = 0; t < 25; t++) begin
      ready_mode = int'($urandom_range(0, 2));
      run_pass(1'($urandom),
               int'($urandom_range(1, RW)),
               int'($urandom_range(1, 20)),
               0, vb,
               1'($urandom),
               0, cyc);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/mvm_result_drain.md
# mvm_result_drain

Controller and result reader for the MVM engine. It launches one MVM pass with a start pulse and tracks the engine's busy flag. It captures the final result vector when busy falls, then streams the vector out one element per beat on a valid/ready port, with an optional ReLU. It also reports the pass latency in cycles and flags an engine that never goes busy.

## Interface
- NUM_BIT, 16, element width; signed two's complement, Q(NUM_BIT-FRAC).FRAC
- DIM, 8, vector length (≥2)
- FRAC, 8, fractional bits (for documentation and test values only; no arithmetic depends on it)
- CNT_W, 24, width of the cycle counter
- RISE_WAIT, 8, number of cycles allowed for i_ismvm to rise after start
- i_clk_drn  in  1  clock. One clock domain; everything is sampled on the rising edge.
- i_rst_n_drn  in  1  reset, synchronous, active-low
- i_go  in  1  request one pass; sampled only in IDLE
- i_relu_en  in  1  ReLU enable; sampled together with an accepted i_go
- o_busy  out  1  high whenever the state is not IDLE
- o_start_mvm  out  1  one-cycle start pulse, wired to the MVM i_start_mvm
- i_ismvm  in  1  MVM busy flag, from MVM o_ismvm
- i_wx_result  in  DIM x NUM_BIT  MVM result vector, from MVM o_wx_result
- o_data  out  NUM_BIT  current output element
- o_idx  out  $clog2(DIM)  index of o_data
- o_valid  out  1  o_data is valid
- i_ready  in  1  downstream accepts the beat
- o_last  out  1  asserted with o_valid when o_idx==DIM-1
- o_cycles  out  CNT_W  latency of the last completed pass
- o_err  out  1  sticky rise timeout

## Operation
- FSM states: IDLE, START, WAIT_RISE, RUN, DRAIN.
- IDLE
  - If i_go=1: latch i_relu_en, clear o_err, go to START.
  - Otherwise stay in IDLE.
- START
  - o_start_mvm=1 for exactly this one cycle (decoded from the state register).
  - Clear the cycle counter to 0 and the rise-wait counter to 0.
  - Go to WAIT_RISE.
- WAIT_RISE
  - If i_ismvm=1: capture i_wx_result into the buffer and go to RUN.
  - Else if the wait counter equals RISE_WAIT-1: set o_err=1 and go to IDLE.
  - Otherwise increment the wait counter.
- RUN
  - If i_ismvm=1: recapture i_wx_result every cycle.
  - If i_ismvm=0: do not capture, latch the cycle counter into o_cycles, and go to DRAIN.
  - The buffer therefore holds the last vector presented while i_ismvm was high.
- DRAIN
  - o_valid=1, o_data=f(buf[idx]), o_idx=idx, o_last=(idx==DIM-1).
  - On o_valid&&i_ready: idx increments. On a transfer with o_last set: idx returns to 0 and the FSM goes to IDLE.
- ReLU: f(v) = 0 if the latched relu_en=1 and v[NUM_BIT-1]=1; otherwise f(v)=v, bit-exact with no rescaling.
- Cycle counter
  - 0 in the START cycle; increments by 1 every following cycle.
  - Saturates at 2^CNT_W-1.
- i_go while busy is ignored; no queuing.
- The block never resets the MVM. The system reset must reset both blocks.

## Timing
- Reset (i_rst_n_drn=0 at an edge) sets:
  - state=IDLE
  - o_busy=0, o_start_mvm=0, o_valid=0, o_last=0, o_err=0
  - o_data=0, o_idx=0, o_cycles=0
  - buffer cleared to 0
- Reset applied in any state aborts the pass at that edge; no partial beats follow.
- i_go=1 sampled at edge k:
  - START and o_start_mvm=1 during cycle k..k+1.
  - o_busy rises at the same edge.
- o_cycles equals (first edge at which i_ismvm is sampled 0 in RUN) minus (START edge), in cycles.
- First o_valid appears in the cycle after the falling sample.
- Beat rules:
  - With i_ready held high: one beat per cycle, DIM cycles total.
  - While o_valid&&!i_ready: o_data, o_idx and o_last stay stable.
- o_busy falls at the edge that accepts the last beat. i_go is then ignored in that cycle and honoured from the next cycle.
- Timeout: o_err rises RISE_WAIT cycles after WAIT_RISE entry. No beats are emitted.
- An i_ismvm glitch during DRAIN is ignored.

## Test plan
- **Basic pass.** MVM model raises ismvm at START+2, first low sample at START+12, result[i]=i·64, i_ready=1 → 8 beats with data 0,64,…,448, o_idx 0..7, o_last only on beat 8, o_cycles=12.
- **Backpressure.** i_ready pattern 1,0,1,0… → each element delivered exactly once and in order; o_data is stable during stalls; o_busy falls on the 8th transfer.
- **ReLU.** result[0]=0xFF00 (-1.0), result[1]=0x0180 (1.5):
  - relu_en=1 → beats 0x0000, 0x0180.
  - relu_en=0 → beats 0xFF00, 0x0180.
- **Timeout.** i_ismvm held 0 → o_err=1 exactly 8 cycles after WAIT_RISE entry; o_busy=0; o_valid never asserted. The next i_go clears o_err.
- **Reset mid-drain.** i_rst_n_drn=0 while o_idx=3 → at the next edge o_valid=0, o_busy=0, o_cycles=0. A following pass completes normally.
- **Go while busy.** i_go pulsed during RUN and again during DRAIN → exactly one o_start_mvm pulse, and the result stream is unchanged.
